// File: rtl/product_accumulator_pkg.sv
// Shared types and constants for the product accumulator and its requantizer.
package product_accumulator_pkg;

    // IDLE: waiting for a start pulse. ACC: summing products. DONE: result is presented.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Product format: bit 14 is the sign, bits 13:0 are the magnitude.
    localparam int PROD_W = 15;

    // Neuron format: bit 7 is the sign, bits 6:0 are the magnitude.
    localparam int NUM_W  = 8;

    // The multiplier decodes this code as unity, so the accumulator must never emit it.
    localparam logic [NUM_W-1:0] UNITY_CODE = 8'h80;

endpackage

// File: rtl/product_accumulator_if.sv
// Handshake bundle between the multiplier, the accumulator and the next-layer consumer.
interface product_accumulator_if
    import product_accumulator_pkg::*;
#(
    parameter int ACC_W = 26
);
    logic                    iStart;
    logic                    iValid;
    logic                    oReady;
    logic [PROD_W-1:0]       iProd;
    logic                    oValid;
    logic                    iReady;
    logic [NUM_W-1:0]        oNum;
    logic signed [ACC_W-1:0] oSum;
    logic                    oBusy;

    modport master (
        output iStart, iValid, iProd, iReady,
        input  oReady, oValid, oNum, oSum, oBusy
    );

    modport slave (
        input  iStart, iValid, iProd, iReady,
        output oReady, oValid, oNum, oSum, oBusy
    );
endinterface

// File: rtl/product_accumulator_requant.sv
// Maps a signed sum to 8-bit sign-magnitude using a right shift, saturation and optional ReLU.
module sm_requant
    import product_accumulator_pkg::*;
#(
    parameter int ACC_W = 26,
    parameter int SHIFT = 7,
    parameter bit RELU  = 1'b1
) (
    input  logic signed [ACC_W-1:0] sum,
    output logic [NUM_W-1:0]        num
);
    logic             neg;
    logic [ACC_W-1:0] abs_v;
    logic [ACC_W-1:0] shifted;
    logic [6:0]       mag;

    // Shift the magnitude so the result truncates toward zero for both signs. A zero magnitude
    // always gives 0x00, which keeps the unity code 0x80 from being produced.
    always_comb begin
        neg     = sum[ACC_W-1];
        abs_v   = neg ? ACC_W'(-sum) : ACC_W'(sum);
        shifted = abs_v >> SHIFT;
        mag     = (shifted > ACC_W'(127)) ? 7'h7F : shifted[6:0];
        num     = '0;
        if ((mag != 7'd0) && !(neg && RELU))
            num = {neg, mag};
    end
endmodule

// File: rtl/product_accumulator.sv
// Accumulates N_TERMS sign-magnitude products into a dot product and requantizes the sum
// to one 8-bit neuron output.
//
// state | meaning
// IDLE  | waiting for iStart; no products are accepted
// ACC   | accepting products; oReady is high
// DONE  | oValid is high; oNum and oSum are held until iReady
module product_accumulator
    import product_accumulator_pkg::*;
#(
    parameter int N_TERMS = 784,
    parameter int ACC_W   = 26,
    parameter int SHIFT   = 7,
    parameter bit RELU    = 1'b1
) (
    input logic                  iClk,
    input logic                  iRst_n,
    product_accumulator_if.slave bus
);
    localparam int              CNT_W = $clog2(N_TERMS);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N_TERMS - 1);

    if (N_TERMS < 2) begin : g_bad_terms
        $error("product_accumulator: N_TERMS must be at least 2");
    end
    if (ACC_W < PROD_W + $clog2(N_TERMS) + 1) begin : g_bad_width
        $error("product_accumulator: ACC_W too narrow for N_TERMS products");
    end

    state_t                  state_q, state_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic signed [ACC_W-1:0] sum_q, sum_d;
    logic [NUM_W-1:0]        num_q, num_d;
    logic signed [ACC_W-1:0] prod_ext;
    logic signed [ACC_W-1:0] acc_next;
    logic [NUM_W-1:0]        rq_num;

    // Convert the incoming product to two's complement; a zero magnitude counts as 0 whatever its sign.
    always_comb begin
        prod_ext = ACC_W'(bus.iProd[PROD_W-2:0]);
        if (bus.iProd[PROD_W-1])
            prod_ext = -prod_ext;
        acc_next = acc_q + prod_ext;
    end

    // The last beat's sum is requantized directly, so the output registers load in the same edge.
    sm_requant #(.ACC_W(ACC_W), .SHIFT(SHIFT), .RELU(RELU)) u_requant (
        .sum (acc_next),
        .num (rq_num)
    );

    // Next-state logic. iStart overrides both a beat and an iReady handshake in the same cycle.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        num_d   = num_q;
        if (bus.iStart) begin
            state_d = ACC;
            acc_d   = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ACC: begin
                    if (bus.iValid) begin
                        acc_d = acc_next;
                        cnt_d = cnt_q + CNT_W'(1);
                        if (cnt_q == LAST) begin
                            state_d = DONE;
                            sum_d   = acc_next;
                            num_d   = rq_num;
                        end
                    end
                end
                DONE: begin
                    if (bus.iReady)
                        state_d = IDLE;
                end
                default: ;
            endcase
        end
    end

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            sum_q   <= '0;
            num_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            num_q   <= num_d;
        end
    end

    // Handshake flags decode from the registered state only.
    always_comb begin
        bus.oReady = (state_q == ACC);
        bus.oValid = (state_q == DONE);
        bus.oBusy  = (state_q != IDLE);
        bus.oNum   = num_q;
        bus.oSum   = sum_q;
    end

    a_no_unity: assert property (@(posedge iClk) disable iff (!iRst_n) bus.oNum != UNITY_CODE);
endmodule

// File: tb/tb_product_accumulator.sv
module tb_product_accumulator;
    localparam int N_TERMS = 4;
    localparam int ACC_W   = 26;
    localparam int SHIFT   = 7;

    logic        iClk;
    logic        iRst_n;
    logic        start;
    logic        valid;
    logic [14:0] prod;
    logic        ready;

    int checks;
    int failures;

    product_accumulator_if #(.ACC_W(ACC_W)) bus0 ();
    product_accumulator_if #(.ACC_W(ACC_W)) bus1 ();

    assign bus0.iStart = start;
    assign bus0.iValid = valid;
    assign bus0.iProd  = prod;
    assign bus0.iReady = ready;
    assign bus1.iStart = start;
    assign bus1.iValid = valid;
    assign bus1.iProd  = prod;
    assign bus1.iReady = ready;

    product_accumulator #(.N_TERMS(N_TERMS), .ACC_W(ACC_W), .SHIFT(SHIFT), .RELU(1'b0)) dut0 (
        .iClk   (iClk),
        .iRst_n (iRst_n),
        .bus    (bus0.slave)
    );

    product_accumulator #(.N_TERMS(N_TERMS), .ACC_W(ACC_W), .SHIFT(SHIFT), .RELU(1'b1)) dut1 (
        .iClk   (iClk),
        .iRst_n (iRst_n),
        .bus    (bus1.slave)
    );

    initial begin
        iClk = 1'b0;
        forever #5 iClk = ~iClk;
    end

    task automatic check_eq(input string tag, input longint obs, input longint exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic beat(input logic [14:0] p);
        valid = 1'b1;
        prod  = p;
        tick();
        valid = 1'b0;
    endtask

    // Back-to-back dot product with result checks on both the RELU=0 and RELU=1 instances.
    task automatic run_dot(input string tag, input logic [14:0] p0, input logic [14:0] p1,
                           input logic [14:0] p2, input logic [14:0] p3, input longint exp_sum,
                           input longint exp_num0, input longint exp_num1);
        pulse_start();
        check_eq({tag, "_ready"}, longint'(bus0.oReady), 1);
        beat(p0);
        beat(p1);
        beat(p2);
        check_eq({tag, "_novalid"}, longint'(bus0.oValid), 0);
        beat(p3);
        check_eq({tag, "_valid"}, longint'(bus0.oValid), 1);
        check_eq({tag, "_sum"}, longint'(bus0.oSum), exp_sum);
        check_eq({tag, "_num_r0"}, longint'(bus0.oNum), exp_num0);
        check_eq({tag, "_num_r1"}, longint'(bus1.oNum), exp_num1);
        check_eq({tag, "_done_ready"}, longint'(bus0.oReady), 0);
        ready = 1'b1;
        tick();
        ready = 1'b0;
        check_eq({tag, "_idle_valid"}, longint'(bus0.oValid), 0);
        check_eq({tag, "_idle_busy"}, longint'(bus0.oBusy), 0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        start    = 1'b0;
        valid    = 1'b0;
        prod     = '0;
        ready    = 1'b0;
        iRst_n   = 1'b0;
        #12;
        check_eq("rst_ready", longint'(bus0.oReady), 0);
        check_eq("rst_valid", longint'(bus0.oValid), 0);
        check_eq("rst_busy", longint'(bus0.oBusy), 0);
        check_eq("rst_num", longint'(bus0.oNum), 0);
        check_eq("rst_sum", longint'(bus0.oSum), 0);
        iRst_n = 1'b1;
        tick();
        check_eq("idle_ready", longint'(bus0.oReady), 0);

        run_dot("pos", 15'h0080, 15'h0080, 15'h0080, 15'h0080, 512, 8'h04, 8'h04);
        run_dot("neg", 15'h0100, 15'h4300, 15'h0000, 15'h0000, -512, 8'h84, 8'h00);
        run_dot("sat", 15'h3FFF, 15'h3FFF, 15'h3FFF, 15'h3FFF, 65532, 8'h7F, 8'h7F);
        run_dot("small", 15'h4000, 15'h0040, 15'h4000, 15'h0000, 64, 8'h00, 8'h00);
        run_dot("smallneg", 15'h4040, 15'h0000, 15'h4000, 15'h0000, -64, 8'h00, 8'h00);

        // Gaps in iValid, then backpressure in DONE with garbage on iProd.
        pulse_start();
        begin
            logic [14:0] gp [4];
            gp[0] = 15'h0080;
            gp[1] = 15'h0080;
            gp[2] = 15'h4040;
            gp[3] = 15'h0010;
            for (int i = 0; i < 4; i++) begin
                int gap;
                gap = int'($urandom_range(0, 2));
                for (int g = 0; g < gap; g++) begin
                    prod = 15'h3FFF;
                    tick();
                end
                beat(gp[i]);
            end
        end
        check_eq("gap_valid", longint'(bus0.oValid), 1);
        check_eq("gap_sum", longint'(bus0.oSum), 208);
        check_eq("gap_num", longint'(bus0.oNum), 8'h01);
        valid = 1'b1;
        prod  = 15'h3FFF;
        for (int c = 0; c < 3; c++) begin
            tick();
            check_eq("bp_valid", longint'(bus0.oValid), 1);
            check_eq("bp_ready", longint'(bus0.oReady), 0);
            check_eq("bp_sum", longint'(bus0.oSum), 208);
            check_eq("bp_num", longint'(bus1.oNum), 8'h01);
        end
        valid = 1'b0;
        ready = 1'b1;
        tick();
        ready = 1'b0;
        check_eq("bp_release_valid", longint'(bus0.oValid), 0);
        check_eq("bp_release_busy", longint'(bus0.oBusy), 0);

        // Abort mid-ACC; the beat accompanying the restart is discarded.
        pulse_start();
        beat(15'h0080);
        beat(15'h0080);
        valid = 1'b1;
        prod  = 15'h0080;
        start = 1'b1;
        tick();
        start = 1'b0;
        valid = 1'b0;
        beat(15'h0100);
        beat(15'h0100);
        beat(15'h0100);
        beat(15'h0100);
        check_eq("abort_valid", longint'(bus0.oValid), 1);
        check_eq("abort_sum", longint'(bus0.oSum), 1024);
        check_eq("abort_num", longint'(bus0.oNum), 8'h08);

        // Restart from DONE wins over a simultaneous iReady.
        ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        ready = 1'b0;
        check_eq("done_abort_valid", longint'(bus0.oValid), 0);
        check_eq("done_abort_ready", longint'(bus0.oReady), 1);

        // Asynchronous reset mid-ACC clears outputs before the next edge.
        beat(15'h0080);
        beat(15'h0080);
        #2;
        iRst_n = 1'b0;
        #1;
        check_eq("mid_rst_ready", longint'(bus0.oReady), 0);
        check_eq("mid_rst_busy", longint'(bus0.oBusy), 0);
        check_eq("mid_rst_num", longint'(bus0.oNum), 0);
        check_eq("mid_rst_sum", longint'(bus0.oSum), 0);
        tick();
        iRst_n = 1'b1;
        tick();
        run_dot("post_rst", 15'h0080, 15'h0080, 15'h0080, 15'h0080, 512, 8'h04, 8'h04);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
